// File: rtl/bundle_decoder.sv
// Receiving end of a NAND-multiplexed bundle: counts excited wires LANES at a time, then threshold-decodes.
// Define BUNDLE_DECODER_STATS_EN to add saturating decoded/ambiguous result counters.
module bundle_decoder #(
  parameter int N         = 10,
  parameter int LANES     = 4,
  parameter int THRESH_HI = 7,
  parameter int THRESH_LO = 3,
  parameter int CW        = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  z_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic          bit_o,
  output logic [CW-1:0] count_o,
  output logic          ambiguous_o,
  output logic          valid_o,
`ifdef BUNDLE_DECODER_STATS_EN
  output logic [15:0]   decoded_cnt_o,
  output logic [15:0]   ambiguous_cnt_o,
  input  logic          ready_i
`else
  input  logic          ready_i
`endif
);

  localparam int K  = (N + LANES - 1) / LANES;
  localparam int SW = K * LANES;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  if (N < 2 || LANES < 1 || LANES > N || THRESH_LO >= THRESH_HI || THRESH_HI > N) begin : g_bad_params
    $error("bundle_decoder: illegal parameters N=%0d LANES=%0d THRESH_LO=%0d THRESH_HI=%0d",
           N, LANES, THRESH_LO, THRESH_HI);
  end

  typedef enum logic [1:0] {IDLE, COUNT, COMPARE, OUTPUT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] shift_q;
  logic [CW-1:0] acc_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] lane_sum;
  logic          last_chunk;
  logic          dec_bit;
  logic          dec_amb;
  logic [CW:0]   acc_x2;

  assign ready_o    = (state_q == IDLE);
  assign last_chunk = (idx_q == IW'(K - 1));
  assign acc_x2     = {acc_q, 1'b0};

  // Padding bits above N are loaded as zero, so summing every lane is safe.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + CW'(shift_q[i]);
    end
  end

  always_comb begin
    dec_bit = 1'b0;
    dec_amb = 1'b0;
    if (acc_q >= CW'(THRESH_HI)) begin
      dec_bit = 1'b1;
    end else if (acc_q > CW'(THRESH_LO)) begin
      dec_amb = 1'b1;
      dec_bit = (acc_x2 > (CW+1)'(N));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = COUNT;
      COUNT:   if (last_chunk) state_d = COMPARE;
      COMPARE: state_d = OUTPUT;
      OUTPUT:  if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q     <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      valid_o     <= 1'b0;
      bit_o       <= 1'b0;
      count_o     <= '0;
      ambiguous_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            shift_q <= SW'(z_i);
            acc_q   <= '0;
            idx_q   <= '0;
          end
        end
        COUNT: begin
          acc_q   <= acc_q + lane_sum;
          shift_q <= shift_q >> LANES;
          idx_q   <= idx_q + IW'(1);
        end
        COMPARE: begin
          bit_o       <= dec_bit;
          ambiguous_o <= dec_amb;
          count_o     <= acc_q;
          valid_o     <= 1'b1;
        end
        OUTPUT: begin
          if (ready_i) valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef BUNDLE_DECODER_STATS_EN
  // Counters advance on the result handshake and stick at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      decoded_cnt_o   <= '0;
      ambiguous_cnt_o <= '0;
    end else if (state_q == OUTPUT && ready_i) begin
      if (decoded_cnt_o != 16'hFFFF) decoded_cnt_o <= decoded_cnt_o + 16'd1;
      if (ambiguous_o && ambiguous_cnt_o != 16'hFFFF) ambiguous_cnt_o <= ambiguous_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bundle_decoder.sv
// Self-checking bench for bundle_decoder: three instances (LANES 4, 3, 1) share stimulus,
// each with its own scoreboard queue; stats counters are checked when BUNDLE_DECODER_STATS_EN is set.
module tb_bundle_decoder;

  localparam int N  = 10;
  localparam int CW = $clog2(N + 1);

  typedef struct {
    logic          exp_bit;
    logic [CW-1:0] exp_cnt;
    logic          exp_amb;
  } exp_t;

  typedef struct {
    logic [N-1:0]  z;
    logic          exp_bit;
    logic [CW-1:0] exp_cnt;
    logic          exp_amb;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  z_i;
  logic          valid_i;
  logic          ready_i;
  logic          ready4, bit4, amb4, valid4;
  logic          ready3, bit3, amb3, valid3;
  logic          ready1, bit1, amb1, valid1;
  logic [CW-1:0] cnt4, cnt3, cnt1;
`ifdef BUNDLE_DECODER_STATS_EN
  logic [15:0]   dec4, ambc4, dec3, ambc3, dec1, ambc1;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t q4[$];
  exp_t q3[$];
  exp_t q1[$];
  vec_t vecs[12];

  always #5 clk = ~clk;

  bundle_decoder #(.N(N), .LANES(4), .THRESH_HI(7), .THRESH_LO(3)) u_l4 (
    .clk(clk), .reset_n(reset_n), .z_i(z_i), .valid_i(valid_i), .ready_o(ready4),
    .bit_o(bit4), .count_o(cnt4), .ambiguous_o(amb4), .valid_o(valid4),
`ifdef BUNDLE_DECODER_STATS_EN
    .decoded_cnt_o(dec4), .ambiguous_cnt_o(ambc4),
`endif
    .ready_i(ready_i));

  bundle_decoder #(.N(N), .LANES(3), .THRESH_HI(7), .THRESH_LO(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .z_i(z_i), .valid_i(valid_i), .ready_o(ready3),
    .bit_o(bit3), .count_o(cnt3), .ambiguous_o(amb3), .valid_o(valid3),
`ifdef BUNDLE_DECODER_STATS_EN
    .decoded_cnt_o(dec3), .ambiguous_cnt_o(ambc3),
`endif
    .ready_i(ready_i));

  bundle_decoder #(.N(N), .LANES(1), .THRESH_HI(7), .THRESH_LO(3)) u_l1 (
    .clk(clk), .reset_n(reset_n), .z_i(z_i), .valid_i(valid_i), .ready_o(ready1),
    .bit_o(bit1), .count_o(cnt1), .ambiguous_o(amb1), .valid_o(valid1),
`ifdef BUNDLE_DECODER_STATS_EN
    .decoded_cnt_o(dec1), .ambiguous_cnt_o(ambc1),
`endif
    .ready_i(ready_i));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkResult(input string tag, input exp_t e, input logic b, input logic [CW-1:0] c, input logic a);
    checkOutput({tag, "_bit"}, 32'(b), 32'(e.exp_bit));
    checkOutput({tag, "_count"}, 32'(c), 32'(e.exp_cnt));
    checkOutput({tag, "_ambiguous"}, 32'(a), 32'(e.exp_amb));
  endtask

  // Reference decode straight from the threshold rules.
  function automatic exp_t model(input logic [N-1:0] z);
    exp_t e;
    int   c = 0;
    for (int i = 0; i < N; i++) c += int'(z[i]);
    e.exp_cnt = CW'(c);
    e.exp_bit = 1'b0;
    e.exp_amb = 1'b0;
    if (c >= 7) e.exp_bit = 1'b1;
    else if (c > 3) begin
      e.exp_amb = 1'b1;
      e.exp_bit = (c * 2 > N);
    end
    return e;
  endfunction

  task automatic waitAllReady();
    int n = 0;
    while (!(ready4 === 1'b1 && ready3 === 1'b1 && ready1 === 1'b1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) checkOutput("ready_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input logic [N-1:0] z, input exp_t e, input bit expect_result);
    waitAllReady();
    z_i     = z;
    valid_i = 1'b1;
    if (expect_result) begin
      q4.push_back(e);
      q3.push_back(e);
      q1.push_back(e);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Results are popped when the handshake is about to complete on the next rising edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && valid4 === 1'b1 && ready_i === 1'b1) begin
      if (q4.size() == 0) checkOutput("l4_unexpected_result", 1, 0);
      else checkResult("l4", q4.pop_front(), bit4, cnt4, amb4);
    end
    if (reset_n === 1'b1 && valid3 === 1'b1 && ready_i === 1'b1) begin
      if (q3.size() == 0) checkOutput("l3_unexpected_result", 1, 0);
      else checkResult("l3", q3.pop_front(), bit3, cnt3, amb3);
    end
    if (reset_n === 1'b1 && valid1 === 1'b1 && ready_i === 1'b1) begin
      if (q1.size() == 0) checkOutput("l1_unexpected_result", 1, 0);
      else checkResult("l1", q1.pop_front(), bit1, cnt1, amb1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    exp_t e;

    vecs[0]  = '{10'h3FF, 1'b1, 4'd10, 1'b0};
    vecs[1]  = '{10'h001, 1'b0, 4'd1,  1'b0};
    vecs[2]  = '{10'h007, 1'b0, 4'd3,  1'b0};
    vecs[3]  = '{10'h07F, 1'b1, 4'd7,  1'b0};
    vecs[4]  = '{10'h03F, 1'b1, 4'd6,  1'b1};
    vecs[5]  = '{10'h01F, 1'b0, 4'd5,  1'b1};
    vecs[6]  = '{10'h000, 1'b0, 4'd0,  1'b0};
    vecs[7]  = '{10'h200, 1'b0, 4'd1,  1'b0};
    vecs[8]  = '{10'h0F0, 1'b0, 4'd4,  1'b1};
    vecs[9]  = '{10'h0FF, 1'b1, 4'd8,  1'b0};
    vecs[10] = '{10'h30F, 1'b1, 4'd6,  1'b1};
    vecs[11] = '{10'h2AA, 1'b0, 4'd5,  1'b1};

    reset_n = 1'b0;
    z_i     = '0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(ready4), 1);
    checkOutput("reset_valid", 32'(valid4), 0);
    checkOutput("reset_bit", 32'(bit4), 0);
    checkOutput("reset_count", 32'(cnt4), 0);
    checkOutput("reset_ambiguous", 32'(amb4), 0);
    checkOutput("reset_ready_l3", 32'(ready3), 1);
    checkOutput("reset_ready_l1", 32'(ready1), 1);
`ifdef BUNDLE_DECODER_STATS_EN
    checkOutput("reset_decoded_cnt", 32'(dec4), 0);
    checkOutput("reset_ambiguous_cnt", 32'(ambc4), 0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accept on E0, valid after E0+4, ready again after E0+5.
    z_i     = 10'h3FF;
    valid_i = 1'b1;
    e = model(10'h3FF);
    q4.push_back(e);
    q3.push_back(e);
    q1.push_back(e);
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("latency_low_e%0d", i), 32'(valid4), 0);
    end
    @(posedge clk); #1;
    checkOutput("latency_valid_e4", 32'(valid4), 1);
    checkOutput("latency_ready_busy", 32'(ready4), 0);
    @(posedge clk); #1;
    checkOutput("latency_ready_e5", 32'(ready4), 1);
    checkOutput("latency_valid_drop", 32'(valid4), 0);

    // Backpressure: result held for 5 cycles, a new bundle offered meanwhile is ignored.
    waitAllReady();
    ready_i = 1'b0;
    applyStimulus(10'h07F, model(10'h07F), 1'b1);
    n = 0;
    while (valid4 !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) checkOutput("hold_valid_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        z_i     = 10'h3FF;
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(valid4), 1);
      checkOutput("hold_ready", 32'(ready4), 0);
      checkOutput("hold_bit", 32'(bit4), 1);
      checkOutput("hold_count", 32'(cnt4), 7);
      checkOutput("hold_ambiguous", 32'(amb4), 0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    waitAllReady();
    checkOutput("hold_queue_drained", 32'(q4.size()), 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_no_second_result", 32'(valid4), 0);
    end

    // Reset during COUNT aborts the bundle without emitting anything.
    applyStimulus(10'h3FF, model(10'h3FF), 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("abort_ready", 32'(ready4), 1);
    checkOutput("abort_valid", 32'(valid4), 0);
    checkOutput("abort_ready_l1", 32'(ready1), 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_result", 32'(valid4 | valid3 | valid1), 0);
    end

    // Three bundles of counts 10, 5, 0 right after reset.
    applyStimulus(10'h3FF, model(10'h3FF), 1'b1);
    applyStimulus(10'h01F, model(10'h01F), 1'b1);
    applyStimulus(10'h000, model(10'h000), 1'b1);
    waitAllReady();
`ifdef BUNDLE_DECODER_STATS_EN
    checkOutput("stats_decoded_l4", 32'(dec4), 3);
    checkOutput("stats_ambiguous_l4", 32'(ambc4), 1);
    checkOutput("stats_decoded_l3", 32'(dec3), 3);
    checkOutput("stats_ambiguous_l3", 32'(ambc3), 1);
    checkOutput("stats_decoded_l1", 32'(dec1), 3);
    checkOutput("stats_ambiguous_l1", 32'(ambc1), 1);
`endif

    for (int i = 0; i < 12; i++) begin
      e.exp_bit = vecs[i].exp_bit;
      e.exp_cnt = vecs[i].exp_cnt;
      e.exp_amb = vecs[i].exp_amb;
      applyStimulus(vecs[i].z, e, 1'b1);
    end

    for (int i = 0; i < 20; i++) begin
      logic [N-1:0] z;
      z = N'($urandom);
      applyStimulus(z, model(z), 1'b1);
    end

    n = 0;
    while ((q4.size() + q3.size() + q1.size()) != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_pending", 32'(q4.size() + q3.size() + q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
